// File: rtl/quad_step_decoder.sv
// quad_step_decoder: quadrature input front end.
// Synchronizes, debounces and Gray-decodes A/B into step/dir.
module quad_step_decoder #(
    parameter int FILTER_CYCLES = 4,
    parameter int X4_MODE       = 1,
    parameter int ERR_W         = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             a_i,
    input  logic             b_i,
    output logic             step_o,
    output logic             dir_o,
    output logic             err_o,
    output logic [ERR_W-1:0] err_count_o
);

    // Filter counter fires on its FILTER_CYCLES-th mismatch cycle.
    localparam logic [7:0] CNT_LAST = 8'(FILTER_CYCLES - 1);

    // Phase pairs are packed {A, B}.
    logic [1:0] s1;
    logic [1:0] s2;
    logic [1:0] f;
    logic [1:0] prev;
    logic [7:0] cnt [2];

    logic is_fwd;
    logic is_rev;
    logic is_bad;
    logic take;
    logic step_d;
    logic dir_d;
    logic err_d;

    // Next state walking forward: 00 -> 10 -> 11 -> 01 -> 00.
    function automatic logic [1:0] fwd_next(input logic [1:0] p);
        logic [1:0] n;
        unique case (p)
            2'b00:   n = 2'b10;
            2'b10:   n = 2'b11;
            2'b11:   n = 2'b01;
            default: n = 2'b00;
        endcase
        return n;
    endfunction

    // Next state walking in reverse: 00 -> 01 -> 11 -> 10 -> 00.
    function automatic logic [1:0] rev_next(input logic [1:0] p);
        logic [1:0] n;
        unique case (p)
            2'b00:   n = 2'b01;
            2'b01:   n = 2'b11;
            2'b11:   n = 2'b10;
            default: n = 2'b00;
        endcase
        return n;
    endfunction

    // Two-flop synchronizer per phase.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            s1 <= 2'b00;
            s2 <= 2'b00;
        end else begin
            s1 <= {a_i, b_i};
            s2 <= s1;
        end
    end

    // Independent debounce per phase: accept after a sustained mismatch.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            f      <= 2'b00;
            cnt[0] <= '0;
            cnt[1] <= '0;
        end else begin
            for (int i = 0; i < 2; i++) begin
                if (s2[i] == f[i]) begin
                    cnt[i] <= '0;
                end else if (cnt[i] == CNT_LAST) begin
                    f[i]   <= s2[i];
                    cnt[i] <= '0;
                end else begin
                    cnt[i] <= cnt[i] + 8'd1;
                end
            end
        end
    end

    // Classify the filtered transition and pick the step to emit.
    always_comb begin
        is_fwd = (f == fwd_next(prev));
        is_rev = (f == rev_next(prev));
        is_bad = (f == ~prev);
        take   = (X4_MODE != 0) || (f == 2'b00);
        step_d = 1'b0;
        dir_d  = dir_o;
        err_d  = 1'b0;
        unique case (1'b1)
            is_bad: err_d = 1'b1;
            is_fwd: begin
                if (take) begin
                    step_d = 1'b1;
                    dir_d  = 1'b0;
                end
            end
            is_rev: begin
                if (take) begin
                    step_d = 1'b1;
                    dir_d  = 1'b1;
                end
            end
            default: ;
        endcase
    end

    // Register decoder outputs; prev tracks f even on illegal cycles.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            prev   <= 2'b00;
            step_o <= 1'b0;
            dir_o  <= 1'b0;
            err_o  <= 1'b0;
        end else begin
            prev   <= f;
            step_o <= step_d;
            dir_o  <= dir_d;
            err_o  <= err_d;
        end
    end

    // Saturating count of illegal transitions.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            err_count_o <= '0;
        end else if (err_d && (err_count_o != '1)) begin
            err_count_o <= err_count_o + 1'b1;
        end
    end

endmodule

// File: tb/tb_quad_step_decoder.sv
// Bench for quad_step_decoder: x4, x1 and 2-bit-counter instances
// driven from one stimulus stream and checked against a Gray-index model.
module tb_quad_step_decoder;

    localparam int FILT = 4;
    localparam int LAT  = FILT + 3;

    typedef struct {
        logic [1:0] ab;
        int         n4;
        int         n1;
        int         ne;
        logic       dir4;
        logic       dir1;
    } vec_t;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       a   = 1'b0;
    logic       b   = 1'b0;

    logic       st4, dr4, er4;
    logic [7:0] ec4;
    logic       st1, dr1, er1;
    logic [7:0] ec1;
    logic       sts, drs, ers;
    logic [1:0] ecs;

    int cyc    = 0;
    int checks = 0;
    int errors = 0;
    int n4 = 0, n1 = 0, ne = 0, nes = 0;

    int ev4 [int];
    int ev1 [int];
    int eve [int];

    logic       m_dir4 = 1'b0;
    logic       m_dir1 = 1'b0;
    int         m_cnt8 = 0;
    int         m_cnts = 0;
    logic [1:0] cur_ab = 2'b00;
    logic [1:0] gray [4];
    vec_t       tbl [$];

    quad_step_decoder #(.FILTER_CYCLES(FILT), .X4_MODE(1), .ERR_W(8)) u_x4 (
        .clk(clk), .rst(rst), .a_i(a), .b_i(b),
        .step_o(st4), .dir_o(dr4), .err_o(er4), .err_count_o(ec4)
    );

    quad_step_decoder #(.FILTER_CYCLES(FILT), .X4_MODE(0), .ERR_W(8)) u_x1 (
        .clk(clk), .rst(rst), .a_i(a), .b_i(b),
        .step_o(st1), .dir_o(dr1), .err_o(er1), .err_count_o(ec1)
    );

    quad_step_decoder #(.FILTER_CYCLES(FILT), .X4_MODE(1), .ERR_W(2)) u_sat (
        .clk(clk), .rst(rst), .a_i(a), .b_i(b),
        .step_o(sts), .dir_o(drs), .err_o(ers), .err_count_o(ecs)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string nm, input logic [31:0] act,
                       input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s cyc=%0d got %0d want %0d", nm, cyc, act, exp);
        end
    endtask

    function automatic int pos_of(input logic [1:0] ab);
        for (int i = 0; i < 4; i++) begin
            if (gray[i] == ab) return i;
        end
        return 0;
    endfunction

    // Drive a new input pair and schedule what it must produce.
    task automatic apply(input logic [1:0] ab);
        int d;
        int t;
        d = (pos_of(ab) - pos_of(cur_ab) + 4) % 4;
        t = cyc + LAT;
        {a, b} = ab;
        if (d == 1) begin
            ev4[t] = 1;
            if (ab == 2'b00) ev1[t] = 1;
        end else if (d == 3) begin
            ev4[t] = 2;
            if (ab == 2'b00) ev1[t] = 2;
        end else if (d == 2) begin
            eve[t] = 1;
        end
        cur_ab = ab;
    endtask

    task automatic move(input logic [1:0] ab, input int hold);
        @(posedge clk);
        #1;
        apply(ab);
        repeat (hold - 1) @(posedge clk);
        #1;
    endtask

    task automatic glitch(input int bitn, input int len);
        logic [1:0] g;
        g       = cur_ab;
        g[bitn] = ~g[bitn];
        @(posedge clk);
        #1;
        {a, b} = g;
        repeat (len) @(posedge clk);
        #1;
        {a, b} = cur_ab;
        repeat (8) @(posedge clk);
        #1;
    endtask

    task automatic reset_clear();
        ev4.delete();
        ev1.delete();
        eve.delete();
        m_dir4 = 1'b0;
        m_dir1 = 1'b0;
        m_cnt8 = 0;
        m_cnts = 0;
        cur_ab = 2'b00;
    endtask

    task automatic do_reset();
        @(posedge clk);
        #1;
        rst = 1'b1;
        reset_clear();
        {a, b} = 2'b00;
        repeat (3) @(posedge clk);
        #1;
        rst = 1'b0;
        apply(2'b00);
        repeat (3) @(posedge clk);
        #1;
    endtask

    task automatic add(input logic [1:0] ab, input int s4, input int s1,
                       input int se, input logic d4, input logic d1);
        vec_t v;
        v.ab   = ab;
        v.n4   = s4;
        v.n1   = s1;
        v.ne   = se;
        v.dir4 = d4;
        v.dir1 = d1;
        tbl.push_back(v);
    endtask

    // Per-cycle scoreboard against the scheduled events.
    always @(negedge clk) begin : mon
        int e4;
        int e1;
        int ee;
        if (rst) begin
            chk("reset_zero",
                {st4, dr4, er4, ec4, st1, dr1, er1, ec1, sts, drs, ers, ecs},
                0);
        end else begin
            e4 = ev4.exists(cyc) ? ev4[cyc] : 0;
            e1 = ev1.exists(cyc) ? ev1[cyc] : 0;
            ee = eve.exists(cyc) ? 1 : 0;
            if (e4 != 0) m_dir4 = (e4 == 2);
            if (e1 != 0) m_dir1 = (e1 == 2);
            if (ee != 0) begin
                if (m_cnt8 < 255) m_cnt8++;
                if (m_cnts < 3) m_cnts++;
            end
            chk("step_x4", st4, (e4 != 0) ? 1 : 0);
            chk("dir_x4", dr4, m_dir4);
            chk("err_x4", er4, ee);
            chk("cnt_x4", ec4, m_cnt8);
            chk("step_x1", st1, (e1 != 0) ? 1 : 0);
            chk("dir_x1", dr1, m_dir1);
            chk("err_x1", er1, ee);
            chk("cnt_x1", ec1, m_cnt8);
            chk("step_sat", sts, (e4 != 0) ? 1 : 0);
            chk("dir_sat", drs, m_dir4);
            chk("err_sat", ers, ee);
            chk("cnt_sat", ecs, m_cnts);
            n4  += int'(st4);
            n1  += int'(st1);
            ne  += int'(er4);
            nes += int'(ers);
        end
    end

    initial begin
        int sat_exp [5];
        int s4, s1, se, s0, first, c0;
        int r, p;
        logic [1:0] nab;

        gray    = '{2'b00, 2'b10, 2'b11, 2'b01};
        sat_exp = '{1, 2, 3, 3, 3};

        add(2'b10, 1, 0, 0, 1'b0, 1'b0);
        add(2'b11, 1, 0, 0, 1'b0, 1'b0);
        add(2'b01, 1, 0, 0, 1'b0, 1'b0);
        add(2'b00, 1, 1, 0, 1'b0, 1'b0);
        add(2'b01, 1, 0, 0, 1'b1, 1'b0);
        add(2'b11, 1, 0, 0, 1'b1, 1'b0);
        add(2'b10, 1, 0, 0, 1'b1, 1'b0);
        add(2'b00, 1, 1, 0, 1'b1, 1'b1);
        add(2'b01, 1, 0, 0, 1'b1, 1'b1);
        add(2'b11, 1, 0, 0, 1'b1, 1'b1);
        add(2'b10, 1, 0, 0, 1'b1, 1'b1);
        add(2'b00, 1, 1, 0, 1'b1, 1'b1);
        add(2'b11, 0, 0, 1, 1'b1, 1'b1);
        add(2'b01, 1, 0, 0, 1'b0, 1'b1);
        add(2'b00, 1, 1, 0, 1'b0, 1'b0);
        add(2'b10, 1, 0, 0, 1'b0, 1'b0);
        add(2'b01, 0, 0, 1, 1'b0, 1'b0);
        add(2'b00, 1, 1, 0, 1'b0, 1'b0);

        repeat (4) @(posedge clk);
        #1;
        rst = 1'b0;
        apply(2'b00);
        repeat (4) @(posedge clk);
        #1;

        // Five illegal moves into a 2-bit counter.
        for (int i = 0; i < 5; i++) begin
            s0 = nes;
            move((i % 2 == 0) ? 2'b11 : 2'b00, 14);
            chk("sat_count", ecs, sat_exp[i]);
            chk("sat_pulses", nes - s0, 1);
        end

        do_reset();

        // Directed vector table.
        for (int i = 0; i < tbl.size(); i++) begin
            s4    = n4;
            s1    = n1;
            se    = ne;
            first = -1;
            @(posedge clk);
            #1;
            c0 = cyc;
            apply(tbl[i].ab);
            for (int k = 0; k < 20; k++) begin
                @(negedge clk);
                if (st4 === 1'b1 && first < 0) first = cyc - c0;
            end
            #1;
            chk("vec_steps_x4", n4 - s4, tbl[i].n4);
            chk("vec_steps_x1", n1 - s1, tbl[i].n1);
            chk("vec_errs", ne - se, tbl[i].ne);
            chk("vec_dir_x4", dr4, tbl[i].dir4);
            chk("vec_dir_x1", dr1, tbl[i].dir1);
            if (i == 0) chk("first_latency", first, LAT);
        end

        // Short glitch is rejected.
        s4 = n4;
        se = ne;
        glitch(1, FILT - 1);
        repeat (10) @(posedge clk);
        #1;
        chk("glitch_steps", n4 - s4, 0);
        chk("glitch_errs", ne - se, 0);

        // A pulse of exactly FILTER_CYCLES is accepted.
        s4 = n4;
        s1 = n1;
        move(2'b10, FILT);
        move(2'b00, 16);
        chk("pulse_steps_x4", n4 - s4, 2);
        chk("pulse_steps_x1", n1 - s1, 1);

        // Random walk with occasional illegal moves and glitches.
        for (int i = 0; i < 80; i++) begin
            r = $urandom_range(0, 7);
            p = pos_of(cur_ab);
            if (r == 0)     nab = ~cur_ab;
            else if (r < 5) nab = gray[(p + 1) % 4];
            else            nab = gray[(p + 3) % 4];
            move(nab, $urandom_range(6, 14));
            if ($urandom_range(0, 3) == 0) begin
                glitch($urandom_range(0, 1), $urandom_range(1, FILT - 1));
            end
        end
        repeat (12) @(posedge clk);
        #1;

        // Reset mid-stream, released with inputs held at 11.
        move(2'b10, 8);
        move(2'b11, 3);
        @(posedge clk);
        #1;
        rst = 1'b1;
        reset_clear();
        for (int k = 0; k < 6; k++) begin
            {a, b} = 2'($urandom);
            @(posedge clk);
            #1;
        end
        {a, b} = 2'b11;
        @(posedge clk);
        #1;
        rst = 1'b0;
        s4 = n4;
        se = ne;
        apply(2'b11);
        repeat (20) @(posedge clk);
        #1;
        chk("rst_release_errs", ne - se, 1);
        chk("rst_release_steps", n4 - s4, 0);
        chk("rst_release_count", ec4, 1);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/quad_step_decoder.md
# quad_step_decoder

Front-end stage that converts a raw two-phase quadrature input (rotary encoder or switch pair) into the step/direction pair consumed by the up/down counter. It synchronizes and debounces both phases, decodes Gray-code transitions into single-cycle step pulses with a direction flag, and flags illegal double-phase transitions. `step_o` connects to the counter's `enable_i`, and `dir_o` connects to its `dir_i`, where 1 means decrement.

## Interface
- `FILTER_CYCLES`, default 4: consecutive cycles a synchronized phase must differ from its filtered value before the filtered value updates. Legal range is 1 to 255.
- `X4_MODE`, default 1: selects the step rate.
  - 1: one step per phase edge, so four steps per Gray cycle.
  - 0: one step per full Gray cycle.
- `ERR_W`, default 8: width of the saturating error counter.

Ports:
- `clk`  in  1  system clock, rising edge.
- `rst`  in  1  reset, asynchronous, active-high.
- `a_i`  in  1  phase A, asynchronous to `clk`.
- `b_i`  in  1  phase B, asynchronous to `clk`.
- `step_o`  out  1  one-cycle step pulse, driving the counter `enable_i`.
- `dir_o`  out  1  direction of the most recent step (0 = forward/increment, 1 = reverse/decrement).
- `err_o`  out  1  one-cycle pulse on an illegal transition.
- `err_count_o`  out  `ERR_W`  saturating count of illegal transitions.

## Operation
- **Synchronizer.** Each phase passes through its own 2-flop synchronizer (`s1`, then `s2`).
- **Filter, per phase, independent.**
  - Keep a filtered bit `f` and a mismatch counter.
  - When `s2` equals `f`, clear the counter.
  - When `s2` differs from `f`, increment the counter. When it reaches `FILTER_CYCLES`, set `f` to `s2` and clear the counter.
  - A mismatch lasting fewer than `FILTER_CYCLES` cycles is discarded.
- **Decoder state.** The decoder holds the previous filtered pair `prev = {fa, fb}` and compares it with the current pair `cur` every cycle.
- **Forward sequence:** 00 → 10 → 11 → 01 → 00 (A leads B).
- **Reverse sequence:** 00 → 01 → 11 → 10 → 00.
- **Transition handling:**
  - `cur` equals `prev`: no event.
  - One bit changed, in forward order: forward event.
  - One bit changed, in reverse order: reverse event.
  - Both bits changed in the same cycle (00↔11 or 01↔10): illegal. Pulse `err_o`, emit no step, leave `dir_o` unchanged.
- **`X4_MODE` = 1:** every forward or reverse event produces a step.
- **`X4_MODE` = 0:** only entry into 00 produces a step.
  - 01 → 00 is a forward step.
  - 10 → 00 is a reverse step.
  - Other legal events update `prev` only.
- **`prev` update.** `prev` is loaded with `cur` every cycle, including illegal cycles, so the decoder resynchronizes after an error.
- **On each step:**
  - `step_o` is 1 for exactly one cycle.
  - `dir_o` is set to 0 for forward or 1 for reverse, registered in the same cycle as `step_o`.
  - `dir_o` holds its value until the next step.
- **Error counter.** `err_count_o` increments on each `err_o` pulse and saturates at 2^`ERR_W` − 1. Only `rst` clears it.
- **Output timing.** All outputs are registered. No combinational path exists from `a_i` or `b_i` to any output.

## Timing
- **Reset values:**
  - `s1`, `s2`, `f`, `prev` = 0 (state 00).
  - Filter counters = 0.
  - `step_o` = 0, `dir_o` = 0, `err_o` = 0, `err_count_o` = 0.
- **Latency.** Let E0 be the edge at which `s1` captures a stable new phase value. Then:
  - `f` updates at E0 + `FILTER_CYCLES` + 1.
  - `step_o` (or `err_o`) is high in the cycle after E0 + `FILTER_CYCLES` + 2. With defaults, this is 6 edges after capture.
- **Throughput.** Step pulses are at least one cycle apart by construction. Phase edges closer than `FILTER_CYCLES` + 1 cycles are not guaranteed to be resolved.
- **Simultaneous phase update.** If both filters update on the same edge, the decoder sees a double change, which is treated as illegal.
- **Reset mid-operation.** Asserting `rst` clears everything immediately (asynchronously).
  - After release, the decoder starts from `prev` = 00.
  - If the inputs are not at 00 on release, the first filtered change is decoded relative to 00. A held 11 therefore produces one `err_o`.
- **Saturation.** At the maximum value, `err_o` still pulses and `err_count_o` holds.

## Test plan
- **Reset.** Assert `rst` mid-stream with the inputs toggling → all outputs are 0 while `rst` is high. After release, `step_o` stays 0 until a filtered change occurs.
- **Forward, x4.** Drive 00→10→11→01→00, each state held 20 cycles, with defaults → 4 `step_o` pulses, each 1 cycle wide, `dir_o` = 0. The first pulse appears 6 edges after `s1` captures A=1. `err_count_o` = 0.
- **Reverse, x1.** With `X4_MODE` = 0, drive two full reverse cycles → exactly 2 pulses with `dir_o` = 1, each on the 10→00 transition. `dir_o` stays 1 afterwards.
- **Glitch rejection.** With `FILTER_CYCLES` = 4, pulse A high for 3 `s2` cycles → no step and no error. Pulse A high for 4 cycles → one forward step.
- **Illegal transition.** Move A and B together from 00 to 11 → `err_o` pulses once, `err_count_o` = 1, no step, `dir_o` unchanged. Then 11→01 is accepted as a forward step.
- **Saturation.** With `ERR_W` = 2, apply 5 illegal transitions → `err_o` pulses 5 times, and `err_count_o` reads 1, 2, 3, 3, 3.
